// File: rtl/bcast_fifo.sv
// Broadcast FIFO: one writer, READER_NUM independent first-word-fall-through readers sharing one store.
// Define BCAST_FIFO_ERR_EN to build the sticky overflow/underflow flags; otherwise they are tied to 0.
module bcast_fifo #(
    parameter int DEPTH_LG2    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int READER_NUM   = 4,
    parameter int AFULL_THRESH = (1 << DEPTH_LG2) - 2,
    parameter bit RST_MEM      = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wren_i,
    input  logic [DATA_WIDTH-1:0]                 wdata_i,
    output logic                                  full_o,
    output logic                                  afull_o,
    input  logic [READER_NUM-1:0]                 rd_active_i,
    input  logic [READER_NUM-1:0]                 rden_i,
    output logic [READER_NUM-1:0]                 empty_o,
    output logic [READER_NUM-1:0][DATA_WIDTH-1:0] rdata_o,
    output logic                                  err_ovf_o,
    output logic [READER_NUM-1:0]                 err_udf_o
);

    localparam int DEPTH = 1 << DEPTH_LG2;
    localparam int PW    = DEPTH_LG2 + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0]         mem [DEPTH];
    logic [PW-1:0]                 wrptr, wrptr_n;
    logic [READER_NUM-1:0][PW-1:0] rdptr, rdptr_n;
    logic                          wr_accept;
    logic [READER_NUM-1:0]         rd_accept;
    logic [READER_NUM-1:0]         empty_n;
    logic [PW-1:0]                 occ;
    logic [PW-1:0]                 occ_max;
    logic                          full_n;
    logic                          afull_n;

    // Inactive readers track the writer so they never hold back the fill level.
    always_comb begin
        wr_accept = wren_i & ~full_o;
        wrptr_n   = wrptr + PW'(wr_accept);
        rd_accept = rden_i & rd_active_i & ~empty_o;
        occ       = '0;
        occ_max   = '0;
        for (int i = 0; i < READER_NUM; i++) begin
            rdptr_n[i] = rd_active_i[i] ? rdptr[i] + PW'(rd_accept[i]) : wrptr_n;
            occ        = wrptr_n - rdptr_n[i];
            empty_n[i] = (wrptr_n == rdptr_n[i]) | ~rd_active_i[i];
            if (rd_active_i[i] && (occ > occ_max)) begin
                occ_max = occ;
            end
        end
        full_n  = (occ_max == DEPTH_P);
        afull_n = (occ_max >= AFULL_P);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrptr   <= '0;
            rdptr   <= '0;
            full_o  <= 1'b0;
            afull_o <= 1'b0;
            empty_o <= '1;
        end else begin
            wrptr   <= wrptr_n;
            rdptr   <= rdptr_n;
            full_o  <= full_n;
            afull_o <= afull_n;
            empty_o <= empty_n;
        end
    end

    generate
        if (RST_MEM) begin : g_mem_rst
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        mem[k] <= '0;
                    end
                end else if (wr_accept) begin
                    mem[wrptr[DEPTH_LG2-1:0]] <= wdata_i;
                end
            end
        end else begin : g_mem
            always_ff @(posedge clk) begin
                if (rst_n && wr_accept) begin
                    mem[wrptr[DEPTH_LG2-1:0]] <= wdata_i;
                end
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < READER_NUM; i++) begin
            rdata_o[i] = mem[rdptr[i][DEPTH_LG2-1:0]];
        end
    end

`ifdef BCAST_FIFO_ERR_EN
    // Flags latch on any attempt the corresponding registered flag would refuse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf_o <= 1'b0;
            err_udf_o <= '0;
        end else begin
            if (wren_i && full_o) begin
                err_ovf_o <= 1'b1;
            end
            err_udf_o <= err_udf_o | (rden_i & empty_o);
        end
    end
`else
    assign err_ovf_o = 1'b0;
    assign err_udf_o = '0;
`endif

endmodule

// File: tb/tb_bcast_fifo.sv
// Testbench for bcast_fifo: per-reader reference queues feed a scoreboard that a
// separate monitor drains whenever the DUT performs a pop; flags are checked every cycle.
module tb_bcast_fifo;

    localparam int DL    = 2;
    localparam int DW    = 8;
    localparam int RN    = 3;
    localparam int AF    = 3;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   wren_i = 1'b0;
    logic [DW-1:0]          wdata_i = '0;
    logic [RN-1:0]          rd_active_i = '1;
    logic [RN-1:0]          rden_i = '0;
    logic                   full_o;
    logic                   afull_o;
    logic [RN-1:0]          empty_o;
    logic [RN-1:0][DW-1:0]  rdata_o;
    logic                   err_ovf_o;
    logic [RN-1:0]          err_udf_o;

    always #5 clk = ~clk;

    bcast_fifo #(
        .DEPTH_LG2   (DL),
        .DATA_WIDTH  (DW),
        .READER_NUM  (RN),
        .AFULL_THRESH(AF),
        .RST_MEM     (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wren_i     (wren_i),
        .wdata_i    (wdata_i),
        .full_o     (full_o),
        .afull_o    (afull_o),
        .rd_active_i(rd_active_i),
        .rden_i     (rden_i),
        .empty_o    (empty_o),
        .rdata_o    (rdata_o),
        .err_ovf_o  (err_ovf_o),
        .err_udf_o  (err_udf_o)
    );

    // Reference state: what each reader still has to see, plus expected registered flags.
    logic [DW-1:0] ref_q [RN][$];
    logic [DW-1:0] sb_q  [RN][$];
    logic          m_full  = 1'b0;
    logic          m_afull = 1'b0;
    logic          m_ovf   = 1'b0;
    logic [RN-1:0] m_empty = '1;
    logic [RN-1:0] m_udf   = '0;
    int            checks  = 0;
    int            errors  = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit wr, input logic [DW-1:0] wd,
                                 input logic [RN-1:0] act, input logic [RN-1:0] rd);
        bit wr_ok;
        @(negedge clk);
        checkOutput("full_o", 32'(full_o), 32'(m_full));
        checkOutput("afull_o", 32'(afull_o), 32'(m_afull));
        checkOutput("empty_o", 32'(empty_o), 32'(m_empty));
        checkOutput("err_ovf_o", 32'(err_ovf_o), 32'(m_ovf));
        checkOutput("err_udf_o", 32'(err_udf_o), 32'(m_udf));
        rst_n       = !rst;
        wren_i      = wr;
        wdata_i     = wd;
        rd_active_i = act;
        rden_i      = rst ? '0 : rd;
        if (rst) begin
            for (int i = 0; i < RN; i++) ref_q[i].delete();
            m_full  = 1'b0;
            m_afull = 1'b0;
            m_empty = '1;
            m_ovf   = 1'b0;
            m_udf   = '0;
        end else begin
            wr_ok = wr && !m_full;
`ifdef BCAST_FIFO_ERR_EN
            if (wr && m_full) m_ovf = 1'b1;
            m_udf = m_udf | (rd & m_empty);
`endif
            for (int i = 0; i < RN; i++) begin
                if (!act[i]) begin
                    ref_q[i].delete();
                end else begin
                    if (rd[i] && ref_q[i].size() > 0) begin
                        sb_q[i].push_back(ref_q[i].pop_front());
                    end
                    if (wr_ok) ref_q[i].push_back(wd);
                end
            end
            m_full  = 1'b0;
            m_afull = 1'b0;
            for (int i = 0; i < RN; i++) begin
                m_empty[i] = !act[i] || (ref_q[i].size() == 0);
                if (act[i] && ref_q[i].size() == DEPTH) m_full = 1'b1;
                if (act[i] && ref_q[i].size() >= AF) m_afull = 1'b1;
            end
        end
    endtask

    // Monitor: whenever the DUT actually pops, its head data must match the oldest expectation.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            for (int i = 0; i < RN; i++) begin
                if (rden_i[i] && rd_active_i[i] && !empty_o[i]) begin
                    if (sb_q[i].size() == 0) begin
                        checkOutput($sformatf("unexpected_pop[%0d]", i), 32'(rdata_o[i]), 32'hFFFF_FFFF);
                    end else begin
                        checkOutput($sformatf("rdata[%0d]", i), 32'(rdata_o[i]), 32'(sb_q[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        $display("[TB] reset released, scenarios starting");

        // Fill without reads, then every reader drains in order.
        applyStimulus(0, 1, 8'h11, 3'b111, 3'b000);
        applyStimulus(0, 1, 8'h22, 3'b111, 3'b000);
        applyStimulus(0, 1, 8'h33, 3'b111, 3'b000);
        applyStimulus(0, 1, 8'h44, 3'b111, 3'b000);
        applyStimulus(0, 0, 8'h00, 3'b111, 3'b000);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 8'h00, 3'b111, 3'b111);

        // Slowest reader alone keeps the FIFO full.
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 8'hA0 + 8'(k), 3'b111, 3'b000);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 8'h00, 3'b111, 3'b011);
        applyStimulus(0, 0, 8'h00, 3'b111, 3'b100);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 8'h00, 3'b111, 3'b100);

        // Write while full is dropped even with a concurrent pop.
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 8'hB0 + 8'(k), 3'b111, 3'b000);
        applyStimulus(0, 1, 8'h55, 3'b111, 3'b001);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 8'h00, 3'b111, 3'b111);

        // Reader 2 inactive during fill, then sees only data written after activation.
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 8'hC0 + 8'(k), 3'b011, 3'b000);
        applyStimulus(0, 0, 8'h00, 3'b111, 3'b000);
        applyStimulus(0, 0, 8'h00, 3'b111, 3'b011);
        applyStimulus(0, 1, 8'h66, 3'b111, 3'b000);
        applyStimulus(0, 0, 8'h00, 3'b111, 3'b100);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 8'h00, 3'b111, 3'b111);

        // Streaming through pointer wrap.
        for (int k = 0; k < 10; k++) applyStimulus(0, 1, 8'(k), 3'b111, 3'b111);
        applyStimulus(0, 0, 8'h00, 3'b111, 3'b111);

        // Reset with data buffered.
        applyStimulus(0, 1, 8'hD0, 3'b111, 3'b000);
        applyStimulus(0, 1, 8'hD1, 3'b111, 3'b000);
        applyStimulus(1, 0, 8'h00, 3'b111, 3'b000);
        applyStimulus(0, 0, 8'h00, 3'b111, 3'b000);

        // Randomized traffic with occasional reader enable changes.
        begin
            logic [RN-1:0] act = '1;
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(0, 15) == 0) act = RN'($urandom);
                applyStimulus(0, ($urandom_range(0, 9) < 6), DW'($urandom), act, RN'($urandom));
            end
        end
        for (int k = 0; k < 6; k++) applyStimulus(0, 0, 8'h00, 3'b111, 3'b111);
        applyStimulus(0, 0, 8'h00, 3'b111, 3'b000);

        @(negedge clk);
        #5;
        for (int i = 0; i < RN; i++) begin
            checkOutput($sformatf("pending_pops[%0d]", i), 32'(sb_q[i].size()), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
